// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and state type for the memory stage
package riscv_pkg;
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register that loads a bubble when told to
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bubble,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_result,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [31:0] o_result
);
    // capture the retiring instruction, or zeros for reset and bubbles
    always_ff @(posedge clk) begin
        if (rst || i_bubble) begin
            o_reg_write <= 1'b0;
            o_rd        <= '0;
            o_result    <= '0;
        end else begin
            o_reg_write <= i_reg_write;
            o_rd        <= i_rd;
            o_result    <= i_result;
        end
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: data-memory handshake, pipeline stall and W-stage write-back
module mem_stage_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memWriteM,
    input  logic        regWriteM,
    input  logic        luiM,
    input  logic [1:0]  resultSrcM,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] writeDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] extImmM,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWData,
    input  logic        dmemGnt,
    input  logic        dmemRValid,
    input  logic [31:0] dmemRData,
    output logic        stallM,
    output logic        regWriteW,
    output logic [4:0]  RdW,
    output logic [31:0] resultW,
    output logic        busErr
);
    mem_state_t       r_state;
    mem_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;
    logic             w_store;
    logic             w_load;
    logic             w_acc;
    logic             w_wait;
    logic             w_rvalid;
    logic             w_timeout;
    logic             w_bubble;
    logic [31:0]      w_result;

    // request/stall decode, next state and write-back select
    always_comb begin
        w_store   = memWriteM;
        w_load    = (resultSrcM == RESULT_MEM) && !memWriteM;
        w_acc     = w_store || w_load;
        w_wait    = r_state == WAIT;
        w_rvalid  = w_wait && dmemRValid;
        w_timeout = w_wait && !dmemRValid && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        dmemReq   = (r_state == IDLE && w_acc) || r_state == REQ;
        dmemWe    = dmemReq && w_store;
        dmemAddr  = dmemReq ? ALUResultM : '0;
        dmemWData = dmemReq ? writeDataM : '0;
        // a granted store is finished this cycle, so the pipe may advance
        stallM    = w_wait ? !(w_rvalid || w_timeout) : dmemReq && !(dmemGnt && w_store);
        w_bubble  = stallM || w_timeout;
        w_next    = w_wait ? ((w_rvalid || w_timeout) ? IDLE : WAIT)
                  : (dmemReq && !dmemGnt) ? REQ
                  : (dmemReq && w_load) ? WAIT : IDLE;
        w_result  = luiM ? extImmM
                  : resultSrcM == RESULT_MEM ? dmemRData
                  : resultSrcM == RESULT_PC4 ? PCPlus4M : ALUResultM;
        busErr    = r_bus_err;
    end

    // access FSM, WAIT-cycle counter and sticky bus error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next == WAIT && w_wait) ? r_cnt + CNT_W'(1) : '0;
            r_bus_err <= r_bus_err || w_timeout;
        end
    end

    mem_wb_reg u_wb (
        .clk         (clk),
        .rst         (rst),
        .i_bubble    (w_bubble),
        .i_reg_write (regWriteM),
        .i_rd        (RdM),
        .i_result    (w_result),
        .o_reg_write (regWriteW),
        .o_rd        (RdW),
        .o_result    (resultW)
    );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed vectors, corner sequences and random traffic against a transaction model
module tb_mem_stage_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memWriteM, regWriteM, luiM;
    logic [1:0]  resultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, writeDataM, PCPlus4M, extImmM;
    logic        dmemReq, dmemWe, dmemGnt, dmemRValid;
    logic [31:0] dmemAddr, dmemWData, dmemRData;
    logic        stallM, regWriteW, busErr;
    logic [4:0]  RdW;
    logic [31:0] resultW;

    int total = 0;
    int bad = 0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .memWriteM(memWriteM), .regWriteM(regWriteM), .luiM(luiM), .resultSrcM(resultSrcM),
        .RdM(RdM), .ALUResultM(ALUResultM), .writeDataM(writeDataM), .PCPlus4M(PCPlus4M),
        .extImmM(extImmM), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
        .dmemWData(dmemWData), .dmemGnt(dmemGnt), .dmemRValid(dmemRValid), .dmemRData(dmemRData),
        .stallM(stallM), .regWriteW(regWriteW), .RdW(RdW), .resultW(resultW), .busErr(busErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mw, rw, lu;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4, imm;
        logic        gnt;
        logic        e_req, e_we, e_stall, e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic set_m(input logic mw, input logic rw, input logic lu, input logic [1:0] src,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4, input logic [31:0] imm);
        memWriteM = mw; regWriteM = rw; luiM = lu; resultSrcM = src; RdM = rd;
        ALUResultM = alu; writeDataM = wd; PCPlus4M = pc4; extImmM = imm;
    endtask

    function automatic logic [31:0] wb(input logic lu, input logic [1:0] src, input logic [31:0] imm,
                                       input logic [31:0] rdata, input logic [31:0] pc4, input logic [31:0] alu);
        if (lu) return imm;
        if (src == 2'b01) return rdata;
        if (src == 2'b10) return pc4;
        return alu;
    endfunction

    // random-phase model state
    logic        g_granted, g_bus, prev_stall;
    int          g_waited;
    logic        e_stall, e_req, e_abort, e_ret, e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_res;

    initial begin
        tv[0] = '{"add",   0,1,0,2'b00,5'd5, 32'h11, 32'h0, 32'h0, 32'h0, 0, 0,0,0,1,5'd5,32'h11};
        tv[1] = '{"store", 1,0,0,2'b00,5'd0, 32'h100,32'hDEADBEEF,32'h0,32'h0, 1, 1,1,0,0,5'd0,32'h100};
        tv[2] = '{"lui",   0,1,1,2'b00,5'd3, 32'h77, 32'h0, 32'h0, 32'h12345000, 0, 0,0,0,1,5'd3,32'h12345000};
        tv[3] = '{"jal",   0,1,0,2'b10,5'd1, 32'h80, 32'h0, 32'h44, 32'h0, 0, 0,0,0,1,5'd1,32'h44};
        tv[4] = '{"src11", 0,1,0,2'b11,5'd8, 32'hABC,32'h0, 32'h55, 32'h0, 0, 0,0,0,1,5'd8,32'hABC};
        tv[5] = '{"x0",    0,1,0,2'b00,5'd0, 32'h99, 32'h0, 32'h0, 32'h0, 0, 0,0,0,1,5'd0,32'h99};
        tv[6] = '{"nogrnt",0,0,0,2'b00,5'd0, 32'h5,  32'h0, 32'h0, 32'h0, 1, 0,0,0,0,5'd0,32'h5};

        rst = 1'b1;
        set_m(0,0,0,2'b00,0,0,0,0,0);
        dmemGnt = 0; dmemRValid = 0; dmemRData = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rw", regWriteW, 0);
        chk("rst_rd", RdW, 0);
        chk("rst_res", resultW, 0);
        chk("rst_buserr", busErr, 0);
        chk("rst_req", dmemReq, 0);
        chk("rst_stall", stallM, 0);
        @(negedge clk) rst = 1'b0;

        // single-cycle vectors
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_m(tv[i].mw, tv[i].rw, tv[i].lu, tv[i].src, tv[i].rd, tv[i].alu, tv[i].wd, tv[i].pc4, tv[i].imm);
            dmemGnt = tv[i].gnt; dmemRValid = 1'b1; dmemRData = 32'h5A5A5A5A;
            #1;
            chk({tv[i].name, "_stall"}, stallM, tv[i].e_stall);
            chk({tv[i].name, "_req"}, dmemReq, tv[i].e_req);
            if (tv[i].e_req) begin
                chk({tv[i].name, "_we"}, dmemWe, tv[i].e_we);
                chk({tv[i].name, "_addr"}, dmemAddr, tv[i].alu);
                chk({tv[i].name, "_wdata"}, dmemWData, tv[i].wd);
            end
            @(posedge clk); #1;
            chk({tv[i].name, "_rw"}, regWriteW, tv[i].e_rw);
            chk({tv[i].name, "_rd"}, RdW, tv[i].e_rd);
            chk({tv[i].name, "_res"}, resultW, tv[i].e_res);
        end

        // load: grant on the third request cycle, data three cycles later; stray gnt/rvalid ignored
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_m(0,1,0,2'b01,7,32'h200,0,32'h10,0);
            dmemGnt = (c == 2) || (c == 4);
            dmemRValid = (c == 1) || (c == 5);
            dmemRData = (c == 5) ? 32'hCAFEF00D : 32'h0BAD0BAD;
            #1;
            chk("ld_stall", stallM, c < 5);
            chk("ld_req", dmemReq, c <= 2);
            if (c <= 2) chk("ld_we", dmemWe, 0);
            @(posedge clk); #1;
            chk("ld_rw", regWriteW, c == 5);
            chk("ld_rd", RdW, (c == 5) ? 32'd7 : 32'd0);
            chk("ld_res", resultW, (c == 5) ? 32'hCAFEF00D : 32'h0);
        end

        // load timeout: no rvalid for TO wait cycles
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_m(0,1,0,2'b01,9,32'h300,0,0,0);
            dmemGnt = (c == 0); dmemRValid = 0;
            #1;
            chk("to_stall", stallM, c < 4);
            @(posedge clk); #1;
            chk("to_rw", regWriteW, 0);
            chk("to_rd", RdW, 0);
            chk("to_buserr", busErr, c == 4);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_m(0,1,0,2'b00,2,32'h7,0,0,0);
            dmemGnt = 0; dmemRValid = 1;
            @(posedge clk); #1;
            chk("sticky_buserr", busErr, 1);
            chk("after_to_rd", RdW, 2);
        end

        // reset while waiting, then a late rvalid
        @(negedge clk);
        set_m(0,1,0,2'b01,4,32'h400,0,0,0);
        dmemGnt = 1; dmemRValid = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1; dmemGnt = 0;
        #1 chk("rw_stall_pre", stallM, 1);
        @(posedge clk); #1;
        chk("rw_rst_rw", regWriteW, 0);
        chk("rw_rst_res", resultW, 0);
        chk("rw_rst_buserr", busErr, 0);
        @(negedge clk);
        rst = 0;
        set_m(0,0,0,2'b00,0,0,0,0,0);
        dmemRValid = 1; dmemRData = 32'h12341234;
        #1;
        chk("rw_late_stall", stallM, 0);
        chk("rw_late_req", dmemReq, 0);
        @(posedge clk); #1;
        chk("rw_late_rw", regWriteW, 0);
        chk("rw_late_rd", RdW, 0);
        chk("rw_late_res", resultW, 0);
        chk("rw_late_buserr", busErr, 0);

        // random traffic against a transaction-level model
        g_granted = 0; g_waited = 0; g_bus = 0; prev_stall = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!prev_stall) begin
                int k;
                k = $urandom_range(0, 5);
                set_m(k == 2, 1'($urandom), k == 3,
                      (k == 1) ? 2'b01 : (k == 4) ? 2'b10 : (k == 5) ? 2'b11 : (k == 2) ? 2'($urandom_range(0, 1)) : 2'b00,
                      5'($urandom), $urandom, $urandom, $urandom, $urandom);
            end
            dmemGnt = ($urandom_range(0, 2) == 0);
            dmemRValid = ($urandom_range(0, 9) < 4);
            dmemRData = $urandom;
            rst = ($urandom_range(0, 149) == 0);
            e_abort = 0; e_ret = 0;
            if (memWriteM) begin
                e_req = 1; e_stall = !dmemGnt; e_ret = dmemGnt;
            end else if (resultSrcM != 2'b01) begin
                e_req = 0; e_stall = 0; e_ret = 1;
            end else if (!g_granted) begin
                e_req = 1; e_stall = 1;
            end else begin
                e_req = 0;
                e_ret = dmemRValid;
                e_abort = !dmemRValid && (g_waited == TO - 1);
                e_stall = !(e_ret || e_abort);
            end
            e_rw  = e_ret ? regWriteM : 1'b0;
            e_rd  = e_ret ? RdM : 5'd0;
            e_res = e_ret ? wb(luiM, resultSrcM, extImmM, dmemRData, PCPlus4M, ALUResultM) : 32'h0;
            #1;
            chk("rnd_stall", stallM, e_stall);
            chk("rnd_req", dmemReq, e_req);
            if (e_req) begin
                chk("rnd_we", dmemWe, memWriteM);
                chk("rnd_addr", dmemAddr, ALUResultM);
                chk("rnd_wdata", dmemWData, writeDataM);
            end
            @(posedge clk);
            if (rst) begin
                g_granted = 0; g_waited = 0; g_bus = 0; prev_stall = 0;
                e_rw = 0; e_rd = 0; e_res = 0;
            end else begin
                if (!memWriteM && resultSrcM == 2'b01 && !g_granted && dmemGnt) begin
                    g_granted = 1; g_waited = 0;
                end else if (g_granted) begin
                    if (e_ret || e_abort) g_granted = 0;
                    else g_waited++;
                end
                g_bus = g_bus || e_abort;
                prev_stall = e_stall;
            end
            #1;
            chk("rnd_rw", regWriteW, e_rw);
            chk("rnd_rd", RdW, e_rd);
            chk("rnd_res", resultW, e_res);
            chk("rnd_buserr", busErr, g_bus);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
